dmem_arbiter: RTL
=================

// Module: dmem_arbiter
// PURPOSE
//  Two-port arbiter/sequencer in front of the single-port data memory (dataMem).
//  Port 0 is the core load/store unit; port 1 is the debug/DMA loader.
//  Round-robin grant, one transaction in flight, valid/ready request and response channels.
//  Drives dataMem we/addr/data_in and absorbs its 1-cycle registered read latency.
// PARAMETERS
//  ADDR_W   `MEM_ADDR_WIDTH   word address width, same as dataMem addr
//  DATA_W   `MEM_DATA_WIDTH   data width, same as dataMem data_in/data_out
// PORTS
//  clk          in   1       clock; one clock domain
//  rst          in   1       reset; synchronous, active-high
//  pN_req_valid in   1       N=0,1: request present
//  pN_req_ready out  1       request accepted this cycle (valid&&ready)
//  pN_req_we    in   1       1=write, 0=read
//  pN_req_addr  in   ADDR_W  word address
//  pN_req_wdata in   DATA_W  write data
//  pN_rsp_valid out  1       response (read data or write ack) present
//  pN_rsp_rdata out  DATA_W  read data; 0 for write acks
//  pN_rsp_ready in   1       requester takes response
//  mem_we       out  1       to dataMem we
//  mem_addr     out  ADDR_W  to dataMem addr
//  mem_wdata    out  DATA_W  to dataMem data_in
//  mem_rdata    in   DATA_W  from dataMem data_out (valid 1 cycle after read issue)
// BEHAVIOUR
//  - One clock; reset is synchronous and active-high.
//  - FSM states: IDLE, ISSUE, WAIT, RESP.
//  - IDLE
//    - Winner: the only valid port; if both are valid, the port != last_grant.
//    - pN_req_ready = 1 combinationally for the winner only, and only in IDLE.
//    - On accept: latch owner, we, addr and wdata into we_q/addr_q/wdata_q; last_grant <= owner; go to ISSUE.
//  - ISSUE (1 cycle)
//    - mem_we = we_q.
//    - Write -> RESP.
//    - Read -> WAIT.
//  - WAIT (1 cycle): rdata_q <= mem_rdata, which is dataMem's registered output from the ISSUE edge; go to RESP.
//  - RESP
//    - Owner's rsp_valid = 1; rsp_rdata = rdata_q, or 0 for a write.
//    - rsp_valid holds stable until rsp_ready; on rsp_ready go to IDLE.
//    - The other port's rsp_valid stays 0.
//  - Outputs outside these rules:
//    - mem_we = 0 in every state except ISSUE with we_q = 1.
//    - mem_addr = addr_q and mem_wdata = wdata_q in all states.
//    - Reads dataMem performs while we = 0 are harmless.
//  - Latency, accept to rsp_valid: write 2 cycles, read 3 cycles.
//  - Minimum occupancy: write 3 cycles, read 4 cycles; no new accept before returning to IDLE.
//  - A requester may drop or change req_* while not accepted, with no effect.
//  - Inputs after accept are ignored; latched values are used.
//  - Fairness: with both ports continuously valid, grants strictly alternate 0,1,0,1.
//  - Reset (in any state, including mid-transaction)
//    - Next state IDLE; all req_ready/rsp_valid/mem_we = 0.
//    - addr_q, wdata_q, rdata_q, we_q = 0; last_grant = 1, so port 0 wins the first tie.
//    - An interrupted transaction is dropped with no response.
//    - A write interrupted in ISSUE is not issued, because reset takes priority over mem_we.
//  - Simultaneous events: a new request arriving in the same cycle as rsp_ready is accepted no earlier than the next cycle (IDLE).
// TESTING
//  1. Reset, p0 write addr 5 = 32'hDEADBEEF.
//     -> p0_req_ready same cycle; mem_we = 1 for exactly one cycle with mem_addr = 5.
//     -> p0_rsp_valid 2 cycles after accept, rsp_rdata = 0.
//  2. p1 read addr 5 after test 1 -> p1_rsp_valid 3 cycles after accept with rsp_rdata = 32'hDEADBEEF; mem_we stays 0.
//  3. Both ports valid from reset, reads to addrs 1 and 2, rsp_ready tied high.
//     -> grant order 0,1,0,1 over 4 transactions.
//     -> each response goes only to its owner.
//  4. Read response with rsp_ready held low for 5 cycles.
//     -> rsp_valid/rsp_rdata stable for all 5 cycles.
//     -> no req_ready to either port; accept resumes the cycle after rsp_ready.
//  5. rst asserted during ISSUE of a write to addr 7 = 32'h12345678.
//     -> mem_we = 0 that cycle; no rsp_valid.
//     -> a subsequent read of addr 7 returns the prior contents.
//  6. p0 changes addr/wdata every cycle after accept.
//     -> memory receives the latched values only, verified by read-back.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter and sequencer in front of the single-port
// data memory. Port 0 is the core load/store unit, port 1 the debug/DMA
// loader. Only one transaction is in flight at a time. The arbiter absorbs
// the memory's one-cycle registered read latency.
module dmem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req_valid,
  output logic              p0_req_ready,
  input  logic              p0_req_we,
  input  logic [ADDR_W-1:0] p0_req_addr,
  input  logic [DATA_W-1:0] p0_req_wdata,
  output logic              p0_rsp_valid,
  output logic [DATA_W-1:0] p0_rsp_rdata,
  input  logic              p0_rsp_ready,
  input  logic              p1_req_valid,
  output logic              p1_req_ready,
  input  logic              p1_req_we,
  input  logic [ADDR_W-1:0] p1_req_addr,
  input  logic [DATA_W-1:0] p1_req_wdata,
  output logic              p1_rsp_valid,
  output logic [DATA_W-1:0] p1_rsp_rdata,
  input  logic              p1_rsp_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic              owner;
  logic              last_grant;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;

  logic              winner;
  logic              accept;
  logic              rsp_active;
  logic              rsp_take;
  logic [DATA_W-1:0] rsp_data;

  // Arbitration and handshake outputs. Reset masks every strobe so that
  // an interrupted write never reaches the memory.
  always_comb begin
    if (p0_req_valid && p1_req_valid) begin
      winner = ~last_grant;
    end else begin
      winner = p1_req_valid;
    end
    accept       = (state == IDLE) && (p0_req_valid || p1_req_valid) && !rst;
    p0_req_ready = accept && !winner;
    p1_req_ready = accept && winner;

    mem_we    = (state == ISSUE) && we_q && !rst;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;

    rsp_active   = (state == RESP) && !rst;
    rsp_data     = we_q ? '0 : rdata_q;
    p0_rsp_valid = rsp_active && !owner;
    p1_rsp_valid = rsp_active && owner;
    p0_rsp_rdata = p0_rsp_valid ? rsp_data : '0;
    p1_rsp_rdata = p1_rsp_valid ? rsp_data : '0;
    rsp_take     = owner ? p1_rsp_ready : p0_rsp_ready;
  end

  // Sequencer next state: writes skip WAIT, reads wait out the memory latency.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ISSUE;
      ISSUE:   state_nxt = we_q ? RESP : WAIT;
      WAIT:    state_nxt = RESP;
      RESP:    if (rsp_take) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, grant history and latched transaction. Reset clears everything
  // and leaves last_grant at 1 so port 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
    end else begin
      state <= state_nxt;
      // accept boundary: request captured, later input changes are ignored
      if (accept) begin
        owner      <= winner;
        last_grant <= winner;
        we_q       <= winner ? p1_req_we    : p0_req_we;
        addr_q     <= winner ? p1_req_addr  : p0_req_addr;
        wdata_q    <= winner ? p1_req_wdata : p0_req_wdata;
      end
      // wait boundary: memory output registered from the issue edge
      if (state == WAIT) begin
        rdata_q <= mem_rdata;
      end
    end
  end

endmodule
